// File: rtl/cic_ctrl_pkg.sv
// Shared types and factor-validation helpers for the CIC decimator controller.
package cic_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        FLUSH,
        SETTLE
    } state_t;

    // ceil(log2(x)) for a 16-bit operand; 0 and 1 both map to 0
    function automatic int unsigned clog2_16(input logic [15:0] x);
        int unsigned r = 0;
        for (int unsigned i = 0; i < 16; i++) begin
            if ((32'd1 << i) < 32'(x)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // A factor is usable if it is in range and its bit growth fits the output width
    function automatic logic factor_ok(
        input logic [15:0] f,
        input int unsigned stages,
        input int unsigned in_w,
        input int unsigned out_w,
        input int unsigned max_f
    );
        return (32'(f) >= 32'd2) && (32'(f) <= max_f) &&
               (stages * clog2_16(f) <= out_w - in_w);
    endfunction

endpackage

// File: rtl/cic_out_buf.sv
// Single-entry valid/ready output buffer with a sticky overrun flag.
module cic_out_buf #(
    parameter int unsigned WIDTH = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample_data,
    input  logic             out_ready,
    input  logic             overrun_clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             overrun
);

    logic load;
    logic drop;

    // A full entry may be replaced only when it is being taken the same cycle
    assign load = load_en && sample_valid && (!out_valid || out_ready);
    assign drop = load_en && sample_valid && out_valid && !out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= sample_data;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cic_dec_ctrl.sv
// Run-time controller for the CIC decimator: factor validation, boundary-aligned
// reconfiguration with flush/settle, and buffered sample delivery.
module cic_dec_ctrl
    import cic_ctrl_pkg::*;
#(
    parameter int unsigned INPUT_WIDTH    = 12,
    parameter int unsigned OUTPUT_WIDTH   = 15,
    parameter int unsigned STAGES         = 2,
    parameter int unsigned MAX_FACTOR     = 1024,
    parameter int unsigned FLUSH_CYCLES   = 2,
    parameter int unsigned SETTLE_OUTPUTS = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic                    cfg_valid,
    input  logic [15:0]             cfg_factor,
    input  logic                    cfg_force,
    output logic                    cfg_ready,
    output logic                    cfg_err,
    output logic                    cic_clk_enable,
    output logic                    cic_reset,
    output logic [15:0]             cic_factor,
    input  logic                    cic_ce_out,
    input  logic [OUTPUT_WIDTH-1:0] cic_data,
    output logic                    out_valid,
    output logic [OUTPUT_WIDTH-1:0] out_data,
    input  logic                    out_ready,
    output logic                    overrun,
    input  logic                    overrun_clr,
    output logic                    busy
);

    localparam int unsigned CNT_MAX = (FLUSH_CYCLES > SETTLE_OUTPUTS) ? FLUSH_CYCLES : SETTLE_OUTPUTS;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      pending;
    logic [15:0]      fac_src;
    logic             accept;
    logic             req_ok;
    logic             pend_load;
    logic             err_next;
    logic             cnt_inc;
    logic             cnt_clr;
    logic             enter_flush;
    logic             load_en;

    assign accept  = cfg_valid && cfg_ready;
    assign req_ok  = factor_ok(cfg_factor, STAGES, INPUT_WIDTH, OUTPUT_WIDTH, MAX_FACTOR);
    assign fac_src = pend_load ? cfg_factor : pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        pend_load   = 1'b0;
        err_next    = 1'b0;
        cnt_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_ok) begin
                        pend_load  = 1'b1;
                        state_next = FLUSH;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    if (req_ok) begin
                        pend_load  = 1'b1;
                        state_next = cfg_force ? FLUSH : DRAIN;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (cic_ce_out) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt == CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_next = SETTLE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            SETTLE: begin
                if (cic_ce_out) begin
                    if (cnt == CNT_W'(SETTLE_OUTPUTS - 1)) begin
                        state_next = RUN;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        cnt_clr     = (state_next != state);
        enter_flush = (state_next == FLUSH) && (state != FLUSH);
    end

    // Registered side outputs derived from the upcoming state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            pending    <= '0;
            cic_factor <= '0;
            cic_reset  <= 1'b1;
            cfg_ready  <= 1'b1;
            cfg_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc && (cnt != CNT_W'(CNT_MAX))) begin
                cnt <= cnt + 1'b1;
            end
            if (pend_load) begin
                pending <= cfg_factor;
            end
            if (enter_flush) begin
                cic_factor <= fac_src;
            end
            cic_reset <= (state_next == IDLE) || (state_next == FLUSH);
            cfg_ready <= (state_next == IDLE) || (state_next == RUN);
            busy      <= (state_next == DRAIN) || (state_next == FLUSH) || (state_next == SETTLE);
            cfg_err   <= err_next;
        end
    end

    assign cic_clk_enable = in_valid && ((state == RUN) || (state == DRAIN) || (state == SETTLE));
    assign load_en        = (state == RUN) || (state == DRAIN);

    cic_out_buf #(
        .WIDTH(OUTPUT_WIDTH)
    ) u_out_buf (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .sample_valid(cic_ce_out),
        .sample_data (cic_data),
        .out_ready   (out_ready),
        .overrun_clr (overrun_clr),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .overrun     (overrun)
    );

endmodule
